// File: rtl/pipeline_hazard_ctrl_if.sv
// Control bundle between the decode/EX stages and the hazard sequencer:
// ID/EX status inputs plus PC, IF/ID and ID/EX write/flush controls and counters.
interface pipeline_hazard_ctrl_if #(
  parameter int CNT_W = 32
);
  logic             id_valid;
  logic [4:0]       id_rs1;
  logic [4:0]       id_rs2;
  logic             id_use_rs1;
  logic             id_use_rs2;
  logic             id_halt;
  logic             id_fence;
  logic             ex_memread;
  logic [4:0]       ex_rd;
  logic             ex_redirect;
  logic             pc_write;
  logic             ifid_write;
  logic             ifid_flush;
  logic             idex_flush;
  logic             halted;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  modport master (
    output id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_halt, id_fence,
    output ex_memread, ex_rd, ex_redirect,
    input  pc_write, ifid_write, ifid_flush, idex_flush, halted, stall_cnt, flush_cnt
  );

  modport slave (
    input  id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_halt, id_fence,
    input  ex_memread, ex_rd, ex_redirect,
    output pc_write, ifid_write, ifid_flush, idex_flush, halted, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline sequencer: load-use stalls, redirect squash, FENCE drain/resume and
// EBREAK/ECALL drain/halt, with saturating stall and flush counters.
module pipeline_hazard_ctrl #(
  parameter int DRAIN_CYCLES = 3,
  parameter int CNT_W        = 32
) (
  input logic                   clk,
  input logic                   rst,
  pipeline_hazard_ctrl_if.slave bus
);
  localparam int DCNT_W = $clog2(DRAIN_CYCLES) + 1;
  localparam logic [DCNT_W-1:0] DRAIN_LAST = DCNT_W'(DRAIN_CYCLES - 1);

  typedef enum logic [1:0] {S_RUN, S_DRAIN, S_HALTED} state_e;
  typedef enum logic [1:0] {K_FENCE = 2'd1, K_HALT = 2'd2} kind_e;

  state_e            state_q, state_d;
  kind_e             kind_q, kind_d;
  logic [DCNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0]  perf_q [2];
  logic [CNT_W-1:0]  perf_d [2];
  logic [1:0]        perf_inc;
  logic              load_use;
  logic              pc_write, ifid_write, ifid_flush, idex_flush, halted;

  assign load_use = bus.ex_memread && (bus.ex_rd != 5'd0) && bus.id_valid &&
                    ((bus.id_use_rs1 && (bus.id_rs1 == bus.ex_rd)) ||
                     (bus.id_use_rs2 && (bus.id_rs2 == bus.ex_rd)));

  always_comb begin
    state_d    = state_q;
    kind_d     = kind_q;
    cnt_d      = cnt_q;
    pc_write   = 1'b0;
    ifid_write = 1'b0;
    ifid_flush = 1'b0;
    idex_flush = 1'b0;
    halted     = 1'b0;
    perf_inc   = 2'b00;
    if (rst) begin
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
      state_d    = S_RUN;
      kind_d     = K_FENCE;
      cnt_d      = '0;
    end else begin
      unique case (state_q)
        S_RUN: begin
          pc_write   = 1'b1;
          ifid_write = 1'b1;
          // Redirect outranks everything: the ID instruction is on the wrong path.
          if (bus.ex_redirect) begin
            ifid_flush  = 1'b1;
            idex_flush  = 1'b1;
            perf_inc[1] = 1'b1;
          end else if (load_use) begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            idex_flush  = 1'b1;
            perf_inc[0] = 1'b1;
          end else if (bus.id_valid && (bus.id_halt || bus.id_fence)) begin
            pc_write   = 1'b0;
            ifid_write = 1'b0;
            idex_flush = 1'b1;
            state_d    = S_DRAIN;
            cnt_d      = DRAIN_LAST;
            kind_d     = bus.id_halt ? K_HALT : K_FENCE;
          end
        end
        S_DRAIN: begin
          idex_flush = 1'b1;
          if (cnt_q == '0) begin
            if (kind_q == K_HALT) begin
              state_d = S_HALTED;
            end else begin
              // FENCE exit: IF/ID overwrites the FENCE with its successor.
              pc_write   = 1'b1;
              ifid_write = 1'b1;
              state_d    = S_RUN;
            end
          end else begin
            cnt_d = cnt_q - DCNT_W'(1);
          end
        end
        S_HALTED: begin
          halted     = 1'b1;
          idex_flush = 1'b1;
        end
        default: state_d = S_RUN;
      endcase
    end
  end

  for (genvar gi = 0; gi < 2; gi++) begin : g_perf
    assign perf_d[gi] = (perf_inc[gi] && (perf_q[gi] != '1)) ? perf_q[gi] + CNT_W'(1)
                                                              : perf_q[gi];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_RUN;
      kind_q    <= K_FENCE;
      cnt_q     <= '0;
      perf_q[0] <= '0;
      perf_q[1] <= '0;
    end else begin
      state_q   <= state_d;
      kind_q    <= kind_d;
      cnt_q     <= cnt_d;
      perf_q[0] <= perf_d[0];
      perf_q[1] <= perf_d[1];
    end
  end

  assign bus.pc_write   = pc_write;
  assign bus.ifid_write = ifid_write;
  assign bus.ifid_flush = ifid_flush;
  assign bus.idex_flush = idex_flush;
  assign bus.halted     = halted;
  assign bus.stall_cnt  = perf_q[0];
  assign bus.flush_cnt  = perf_q[1];
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Scoreboard bench: a driver applies one stimulus per cycle and queues the
// behavioural model's expected outputs; a monitor pops and compares each cycle.
module tb_pipeline_hazard_ctrl;
  localparam int DRAIN_CYCLES = 3;
  localparam int CNT_W        = 4;
  localparam int CNT_MAX      = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pipeline_hazard_ctrl_if #(.CNT_W(CNT_W)) bus ();

  pipeline_hazard_ctrl #(.DRAIN_CYCLES(DRAIN_CYCLES), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  typedef struct packed {
    bit       rst;
    bit       valid;
    bit [4:0] rs1;
    bit [4:0] rs2;
    bit       u1;
    bit       u2;
    bit       halt;
    bit       fence;
    bit       memread;
    bit [4:0] rd;
    bit       redirect;
  } stim_t;

  typedef struct {
    logic [4:0]       ctl;   // pc_write, ifid_write, ifid_flush, idex_flush, halted
    logic [CNT_W-1:0] stall;
    logic [CNT_W-1:0] flush;
    string            tag;
  } exp_t;

  exp_t sb_q[$];
  int   checks   = 0;
  int   failures = 0;
  int   txn      = 0;

  // Reference model: counts of cycles, not state encodings.
  int m_stall      = 0;
  int m_flush      = 0;
  int m_drain_left = 0;
  bit m_halted     = 1'b0;
  bit m_drain_halt = 1'b0;

  task automatic model(input stim_t s, output exp_t e);
    bit lu;
    e.stall = CNT_W'(m_stall);
    e.flush = CNT_W'(m_flush);
    if (s.rst) begin
      e.ctl        = 5'b00110;
      m_stall      = 0;
      m_flush      = 0;
      m_drain_left = 0;
      m_halted     = 1'b0;
    end else if (m_halted) begin
      e.ctl = 5'b00011;
    end else if (m_drain_left > 0) begin
      e.ctl = 5'b00010;
      m_drain_left--;
      if (m_drain_left == 0) begin
        if (m_drain_halt) m_halted = 1'b1;
        else              e.ctl = 5'b11010;
      end
    end else begin
      lu = s.memread && (s.rd != 0) && s.valid &&
           ((s.u1 && s.rs1 == s.rd) || (s.u2 && s.rs2 == s.rd));
      if (s.redirect) begin
        e.ctl = 5'b11110;
        if (m_flush < CNT_MAX) m_flush++;
      end else if (lu) begin
        e.ctl = 5'b00010;
        if (m_stall < CNT_MAX) m_stall++;
      end else if (s.valid && (s.halt || s.fence)) begin
        e.ctl        = 5'b00010;
        m_drain_left = DRAIN_CYCLES;
        m_drain_halt = s.halt;
      end else begin
        e.ctl = 5'b11000;
      end
    end
  endtask

  task automatic apply(input stim_t s, input string tag);
    exp_t e;
    @(posedge clk);
    #1;
    rst            = s.rst;
    bus.id_valid   = s.valid;
    bus.id_rs1     = s.rs1;
    bus.id_rs2     = s.rs2;
    bus.id_use_rs1 = s.u1;
    bus.id_use_rs2 = s.u2;
    bus.id_halt    = s.halt;
    bus.id_fence   = s.fence;
    bus.ex_memread = s.memread;
    bus.ex_rd      = s.rd;
    bus.ex_redirect = s.redirect;
    model(s, e);
    e.tag = tag;
    sb_q.push_back(e);
  endtask

  function automatic stim_t rand_stim(input int rst_pct, input int halt_pct);
    stim_t s;
    s          = '0;
    s.rst      = ($urandom_range(99) < rst_pct);
    s.valid    = ($urandom_range(99) < 85);
    s.rs1      = 5'($urandom_range(7));
    s.rs2      = 5'($urandom_range(7));
    s.u1       = $urandom_range(1);
    s.u2       = $urandom_range(1);
    s.halt     = ($urandom_range(99) < halt_pct);
    s.fence    = ($urandom_range(99) < 8);
    s.memread  = $urandom_range(1);
    s.rd       = 5'($urandom_range(7));
    s.redirect = ($urandom_range(99) < 15);
    return s;
  endfunction

  function automatic stim_t lu_stim(input bit [4:0] rd);
    stim_t s;
    s         = '0;
    s.valid   = 1'b1;
    s.rs1     = rd;
    s.u1      = 1'b1;
    s.rs2     = 5'd9;
    s.memread = 1'b1;
    s.rd      = rd;
    return s;
  endfunction

  // Monitor: one comparison per presented output cycle.
  initial begin
    exp_t e;
    logic [5+2*CNT_W-1:0] got, want;
    forever begin
      @(negedge clk);
      if (sb_q.size() > 0) begin
        e    = sb_q.pop_front();
        got  = {bus.pc_write, bus.ifid_write, bus.ifid_flush, bus.idex_flush, bus.halted,
                bus.stall_cnt, bus.flush_cnt};
        want = {e.ctl, e.stall, e.flush};
        checks++;
        txn++;
        if (got !== want)  begin
          failures++;
          $display("FAIL %s txn=%0d got pc/ifw/iff/idf/halt=%b stall=%0d flush=%0d required %b stall=%0d flush=%0d",
                   e.tag, txn, got[5+2*CNT_W-1 -: 5], got[2*CNT_W-1 -: CNT_W], got[CNT_W-1:0],
                   e.ctl, e.stall, e.flush);
        end else begin
          $display("txn %0d %s ctl=%b stall=%0d flush=%0d ok", txn, e.tag, e.ctl, e.stall, e.flush);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached, checks=%0d", checks);
    $fatal(1, "timeout");
  end

  initial begin
    stim_t s;
    bus.id_valid = 1'b0; bus.id_rs1 = '0; bus.id_rs2 = '0; bus.id_use_rs1 = 1'b0;
    bus.id_use_rs2 = 1'b0; bus.id_halt = 1'b0; bus.id_fence = 1'b0;
    bus.ex_memread = 1'b0; bus.ex_rd = '0; bus.ex_redirect = 1'b0;

    // Reset with random inputs
    for (int i = 0; i < 2; i++) begin
      s = rand_stim(0, 5); s.rst = 1'b1; apply(s, "reset");
    end

    // Load-use on x5, then the reissued add proceeds; rd=x0 never stalls
    apply(lu_stim(5'd5), "loaduse_x5");
    s = lu_stim(5'd5); s.memread = 1'b0; apply(s, "after_stall");
    apply(lu_stim(5'd0), "loaduse_x0");
    s = lu_stim(5'd6); s.u1 = 1'b0; s.rs2 = 5'd6; s.u2 = 1'b1; apply(s, "loaduse_rs2");

    // Redirect beats halt and load-use together
    s = lu_stim(5'd7); s.halt = 1'b1; s.redirect = 1'b1; apply(s, "redirect_prio");
    apply('0, "after_redirect");

    // FENCE: three frozen cycles, an exit cycle, then RUN
    s = '0; s.rst = 1'b1; apply(s, "reset");
    s = '0; s.valid = 1'b1; s.fence = 1'b1; apply(s, "fence");
    for (int i = 0; i < 5; i++) begin
      s = rand_stim(0, 0); s.halt = 1'b0; s.fence = 1'b0; apply(s, "fence_drain");
    end

    // Halt: drains, then holds under random traffic
    s = '0; s.valid = 1'b1; s.halt = 1'b1; s.fence = 1'b1; apply(s, "halt");
    for (int i = 0; i < 104; i++) apply(rand_stim(0, 20), "halted_hold");

    // Reset in the second DRAIN cycle aborts the halt
    s = '0; s.rst = 1'b1; apply(s, "reset");
    s = '0; s.valid = 1'b1; s.halt = 1'b1; apply(s, "halt2");
    apply('0, "drain1");
    s = rand_stim(0, 0); s.rst = 1'b1; apply(s, "rst_mid_drain");
    for (int i = 0; i < 6; i++) apply('0, "post_abort");

    // Saturation of the 4-bit stall counter
    s = '0; s.rst = 1'b1; apply(s, "reset");
    for (int i = 0; i < 22; i++) begin
      apply(lu_stim(5'(1 + (i % 31))), "sat_stall");
      apply('0, "sat_gap");
    end

    // Randomised traffic with occasional reset
    for (int i = 0; i < 400; i++) apply(rand_stim(3, 3), "random");

    for (int i = 0; i < 4 && sb_q.size() > 0; i++) @(negedge clk);
    @(negedge clk);
    if (sb_q.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL scoreboard_drain pending=%0d required 0", sb_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
